pred_writeback: RTL
===================

Name: pred_writeback

Overview:
- Consumer end of the intra predictor's output interface.
- Accepts one 4x4 predicted block per handshake and writes it into reconstruction memory one row per cycle, in raster block order.
- Keeps the neighbour edges (above row and left column) up to date, so the next block's predictor inputs can be driven straight from this block.
- Closes the loop between smooth_mode's pred output and its aboveRow/leftCol inputs.

Parameters:
- SAMPLE_W, 30, bits per sample (matches the predictor sample width).
- FRAME_W_BLK, 8, frame width in 4x4 blocks (power of two not required, >=2).
- FRAME_H_BLK, 8, frame height in 4x4 blocks (>=1).
- ADDR_W, 10, memory word address width; must satisfy 2^ADDR_W >= 4*FRAME_W_BLK*FRAME_H_BLK.
- EDGE_DEFAULT, 512, sample value substituted for neighbours outside the frame.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  pulse; resets block position to (0,0). Honoured only in IDLE, otherwise ignored.
- in_valid  in  1  pred block valid.
- in_ready  out  1  high only in IDLE.
- pred  in  SAMPLE_W x [0:3][0:3]  predicted block, indexed [row][col].
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  word address = (blk_y*4 + r)*FRAME_W_BLK + blk_x.
- wr_data  out  4*SAMPLE_W  one block row; col 0 in the LSBs.
- above_row  out  SAMPLE_W x [0:7]  above (0..3) plus above-right (4..7) for the next block.
- left_col  out  SAMPLE_W x [0:3]  left neighbour column for the next block.
- blk_x  out  clog2(FRAME_W_BLK)  position of the next block to be accepted.
- blk_y  out  clog2(FRAME_H_BLK)  position of the next block to be accepted.
- frame_done  out  1  one-cycle pulse when the last block of the frame has been written.

Behaviour:
- Reset (asynchronous, any state):
  - State IDLE; wr_en, frame_done, wr_addr, wr_data = 0; blk_x, blk_y = 0.
  - Line buffer and left register cleared.
  - A reset mid-write abandons the remaining rows; no further wr_en.
- FSM states and transitions:
  - IDLE: in_ready = 1. in_valid & in_ready captures pred into a holding register; next state WRITE.
  - WRITE: a row counter r runs 0..3. Each cycle drives wr_en=1, wr_addr per the formula, wr_data = row r. After r=3, next state UPDATE.
  - UPDATE: wr_en = 0.
    - Copy bottom row (row 3) into line buffer entries blk_x*4..blk_x*4+3.
    - Copy right column (col 3) into the left register.
    - Advance the position: blk_x+1; at FRAME_W_BLK-1, wrap blk_x to 0 and increment blk_y.
    - At the last block (FRAME_W_BLK-1, FRAME_H_BLK-1), wrap to (0,0) and pulse frame_done.
    - Next state IDLE.
- Timing: handshake in cycle 0; wr_en in cycles 1-4; UPDATE in cycle 5; in_ready high from cycle 6. Throughput is 1 block per 6 cycles.
- Line buffer: FRAME_W_BLK*4 samples of registers, indexed by column.
- Edge outputs are registered and valid whenever in_ready = 1, computed for the current (blk_x, blk_y):
  - above_row[0..3]: line buffer at blk_x*4..+3, or EDGE_DEFAULT when blk_y == 0.
  - above_row[4..7]: line buffer at (blk_x+1)*4..+3. When blk_x == FRAME_W_BLK-1, use above_row[3] replicated. EDGE_DEFAULT when blk_y == 0.
  - left_col: the left register, or EDGE_DEFAULT when blk_x == 0.
- On wrap to (0,0), stale line buffer contents are never visible because blk_y == 0 forces the default.
- frame_start and in_valid asserted together in IDLE: frame_start applies first, and the block is accepted at (0,0).
- Samples pass through unmodified; no clipping or arithmetic on sample values.

Decomposition:
- Package av1_pkg holds:
  - SAMPLE_W;
  - typedef sample_t (logic [SAMPLE_W-1:0]);
  - typedef blk4_t (sample_t [0:3][0:3]);
  - typedef row4_t (sample_t [0:3]);
  - enum wb_state_t {IDLE, WRITE, UPDATE}.
- One natural sub-module: edge_line_buffer. It owns the line buffer plus the left register, takes a write port from UPDATE, and does the default/replication muxing for above_row and left_col.

Test Plan:
- Reset check: after reset, in_ready=1, blk_x=blk_y=0, wr_en=0, above_row all 512, left_col all 512.
- Single block pred[r][c] = 16*r + c:
  - Expect wr_en in cycles 1-4 at addresses 0, 8, 16, 24.
  - wr_data row 0 = {3, 2, 1, 0}.
  - blk_x = 1 at cycle 6.
  - left_col = {3, 19, 35, 51}.
- Second row of blocks: write 8 blocks where block n is all value n.
  - blk_y becomes 1.
  - Block (0,1): above_row[0..3] = 0, above_row[4..7] = 1, left_col = 512.
  - Block (7,1) above-right = replicated 7.
- Full frame of 64 blocks: frame_done pulses exactly once, on the 64th UPDATE, and the position wraps to (0,0). Above_row then returns to 512.
- Reset asserted in WRITE at r=2: wr_en drops immediately, blk_x=0, in_ready=1 once rst_n is released.
- frame_start at position (3,2) in IDLE resets to (0,0). A frame_start pulse during WRITE is ignored: position still advances normally.

Source files
------------

// File: rtl/av1_pkg.sv
// Shared sample and block types for the intra prediction path.
package av1_pkg;

  localparam int SAMPLE_W = 30;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [0:3]       row4_t;
  typedef sample_t [0:3][0:3]  blk4_t;
  typedef sample_t [0:7]       edge8_t;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    UPDATE
  } wb_state_t;

endpackage

// File: rtl/edge_line_buffer.sv
// Neighbour-edge storage: one frame-wide line of bottom-row samples plus the
// previous block's right column, muxed into above/left edges for the next block.
module edge_line_buffer
  import av1_pkg::*;
#(
  parameter int FRAME_W_BLK  = 8,
  parameter int XW           = 3,
  parameter int EDGE_DEFAULT = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [XW-1:0] wr_x_i,
  input  row4_t         bottom_i,
  input  row4_t         right_i,
  input  logic [XW-1:0] rd_x_i,
  input  logic          rd_top_i,
  input  logic          rd_first_col_i,
  output edge8_t        above_row_o,
  output row4_t         left_col_o
);

  localparam int      LINE_N = FRAME_W_BLK * 4;
  localparam sample_t DEF    = sample_t'(EDGE_DEFAULT);

  sample_t line_q [LINE_N];
  row4_t   left_q;
  int      base_idx;
  logic    rd_last_x;

  // NOTE: the line is a small register file, not RAM, so it can and does take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_N; i++) line_q[i] <= '0;
      left_q <= '0;
    end else if (wr_en_i) begin
      for (int c = 0; c < 4; c++) line_q[int'(wr_x_i) * 4 + c] <= bottom_i[c];
      left_q <= right_i;
    end
  end

  // NOTE: every output gets a value on every path through this block, so no latch can form.
  always_comb begin
    base_idx  = int'(rd_x_i) * 4;
    rd_last_x = (int'(rd_x_i) == FRAME_W_BLK - 1);
    for (int i = 0; i < 4; i++) begin
      above_row_o[i]     = rd_top_i ? DEF : line_q[base_idx + i];
      above_row_o[4 + i] = rd_top_i  ? DEF :
                           rd_last_x ? line_q[base_idx + 3] : line_q[base_idx + 4 + i];
      left_col_o[i]      = rd_first_col_i ? DEF : left_q[i];
    end
  end

endmodule

// File: rtl/pred_writeback.sv
// Writes predicted 4x4 blocks to reconstruction memory a row per cycle in raster
// order, and keeps the neighbour edges ready for the next block.
module pred_writeback
  import av1_pkg::*;
#(
  parameter int  FRAME_W_BLK  = 8,
  parameter int  FRAME_H_BLK  = 8,
  parameter int  ADDR_W       = 10,
  parameter int  EDGE_DEFAULT = 512,
  localparam int XW = (FRAME_W_BLK > 1) ? $clog2(FRAME_W_BLK) : 1,
  localparam int YW = (FRAME_H_BLK > 1) ? $clog2(FRAME_H_BLK) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  blk4_t                 pred,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [4*SAMPLE_W-1:0] wr_data,
  output edge8_t                above_row,
  output row4_t                 left_col,
  output logic [XW-1:0]         blk_x,
  output logic [YW-1:0]         blk_y,
  output logic                  frame_done
);

  wb_state_t     state_q, state_d;
  logic [1:0]    row_q, row_d;
  blk4_t         blk_q, blk_d;
  logic [XW-1:0] blk_x_q, blk_x_d;
  logic [YW-1:0] blk_y_q, blk_y_d;
  logic          last_x, last_y;
  row4_t         cur_row, right_col;
  int            addr_int;

  assign last_x = (blk_x_q == XW'(FRAME_W_BLK - 1));
  assign last_y = (blk_y_q == YW'(FRAME_H_BLK - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      blk_q   <= '0;
      blk_x_q <= '0;
      blk_y_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      blk_x_q <= blk_x_d;
      blk_y_q <= blk_y_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    blk_d   = blk_q;
    blk_x_d = blk_x_q;
    blk_y_d = blk_y_q;
    unique case (state_q)
      IDLE: begin
        // frame_start takes effect on the same edge, so a coincident block lands at (0,0).
        if (frame_start) begin
          blk_x_d = '0;
          blk_y_d = '0;
        end
        if (in_valid) begin
          blk_d   = pred;
          row_d   = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) state_d = UPDATE;
      end
      UPDATE: begin
        if (last_x) begin
          blk_x_d = '0;
          blk_y_d = last_y ? '0 : blk_y_q + YW'(1);
        end else begin
          blk_x_d = blk_x_q + XW'(1);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_row  = blk_q[row_q];
    addr_int = (int'(blk_y_q) * 4 + int'(row_q)) * FRAME_W_BLK + int'(blk_x_q);
    for (int r = 0; r < 4; r++) right_col[r] = blk_q[r][3];
    in_ready   = (state_q == IDLE);
    wr_en      = (state_q == WRITE);
    wr_addr    = wr_en ? ADDR_W'(addr_int) : '0;
    wr_data    = wr_en ? {cur_row[3], cur_row[2], cur_row[1], cur_row[0]} : '0;
    frame_done = (state_q == UPDATE) && last_x && last_y;
  end

  assign blk_x = blk_x_q;
  assign blk_y = blk_y_q;

  edge_line_buffer #(
    .FRAME_W_BLK  (FRAME_W_BLK),
    .XW           (XW),
    .EDGE_DEFAULT (EDGE_DEFAULT)
  ) u_edges (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en_i        (state_q == UPDATE),
    .wr_x_i         (blk_x_q),
    .bottom_i       (blk_q[3]),
    .right_i        (right_col),
    .rd_x_i         (blk_x_q),
    .rd_top_i       (blk_y_q == '0),
    .rd_first_col_i (blk_x_q == '0),
    .above_row_o    (above_row),
    .left_col_o     (left_col)
  );

endmodule
